add_sub_seq: RTL
================

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 SHALL have parameter: SIZE, 4, operand/result width in bits.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: in_valid  in  1  upstream word valid.
REQ-005 SHALL have port: in_ready  out  1  block accepts in_data this cycle.
REQ-006 SHALL have port: in_data  in  SIZE  operand word; first accepted word is A, second is B.
REQ-007 SHALL have port: in_sub  in  1  operation select; sampled only with B (1 = A-B, 0 = A+B).
REQ-008 SHALL have port: op_a  out  SIZE  registered A, drives the downstream add_sub A input.
REQ-009 SHALL have port: op_b  out  SIZE  registered B, drives the add_sub B input.
REQ-010 SHALL have port: op_sub  out  1  registered sub, drives the add_sub sub input.
REQ-011 SHALL have port: res_s  in  SIZE  combinational sum/difference returned by add_sub.
REQ-012 SHALL have port: res_cout  in  1  carry returned by add_sub; for subtract, 1 = no borrow.
REQ-013 SHALL have port: out_valid  out  1  result held and valid.
REQ-014 SHALL have port: out_ready  in  1  downstream consumes result.
REQ-015 SHALL have port: out_s, out_cout, out_ovf  out  SIZE/1/1  captured result, carry, signed overflow.
REQ-016 SHALL have port: txn_cnt  out  8  count of completed output handshakes.

Function
REQ-017 SHALL implement FSM states GET_A, GET_B, EXEC, HOLD.
REQ-018 In GET_A: in_ready=1; on in_valid, op_a<=in_data and go to GET_B; otherwise stay.
REQ-019 In GET_B: in_ready=1; on in_valid, op_b<=in_data, op_sub<=in_sub, go to EXEC; otherwise stay; in_valid gaps of any length are allowed.
REQ-020 In EXEC: in_ready=0; capture out_s<=res_s, out_cout<=res_cout, out_ovf<=computed overflow; go to HOLD.
REQ-021 In HOLD: in_ready=0, out_valid=1; out_s/out_cout/out_ovf and op_* stable until out_valid&&out_ready, then go to GET_A and increment txn_cnt.
REQ-022 Latency: A accepted in cycle n, B accepted in cycle n+1, EXEC in cycle n+2, out_valid high from cycle n+3.
REQ-023 Overflow for add SHALL be (a_msb==b_msb)&&(s_msb!=a_msb); for sub, (a_msb!=b_msb)&&(s_msb!=a_msb), using op_a/op_b/res_s MSBs.
REQ-024 out_valid SHALL be registered, asserted only in HOLD; in_ready SHALL be a decode of state (GET_A or GET_B).
REQ-025 txn_cnt SHALL wrap from 255 to 0 without a flag.
REQ-026 in_valid in EXEC/HOLD SHALL be ignored; no input word is consumed.
REQ-027 out_ready while out_valid=0 SHALL have no effect.
REQ-028 op_a/op_b/op_sub SHALL change only on accepted words, never in EXEC/HOLD.

Reset
REQ-029 On rst_n low, the block SHALL immediately go to GET_A and clear op_a, op_b, op_sub, out_s, out_cout, out_ovf, out_valid, and txn_cnt to 0, with in_ready=1 after release.
REQ-030 Reset mid-transaction (any state) SHALL discard any partial A/B or held result; the first word after release is treated as A.

Verification
REQ-031 SIZE=4, A=3, B=5, sub=0 -> out_s=8, out_cout=0, out_ovf=1, out_valid at cycle n+3, txn_cnt=1 after handshake.
REQ-032 A=2, B=5, sub=1 -> out_s=13, out_cout=0 (borrow), out_ovf=0.
REQ-033 A=15, B=1, sub=0 -> out_s=0, out_cout=1, out_ovf=0; then A=9, B=4, sub=1 -> out_s=5, out_cout=1, out_ovf=1.
REQ-034 out_ready held low 5 cycles in HOLD, with in_valid=1 and changing in_data -> out_valid stays 1, outputs and op_* unchanged, in_ready=0, no word consumed.
REQ-035 in_valid dropped 3 cycles between A and B -> result identical to no-gap case; in_sub sampled with A is ignored, only in_sub with B is used.
REQ-036 rst_n pulsed low after A accepted -> all outputs 0, state GET_A; next pair A=7, B=1, sub=0 -> out_s=8, out_ovf=1.

Source files
------------

// File: rtl/add_sub_seq_if.sv
// Operand-in / result-out handshake bundle for add_sub_seq.
// The upstream producer and downstream consumer use the master side.
// The sequencer uses the slave side.
interface add_sub_seq_if #(
  parameter int SIZE = 4
);
  // Operand stream: word A, then word B together with its op select
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_data;
  logic            in_sub;

  // Result stream: held result with carry and signed overflow
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_s;
  logic            out_cout;
  logic            out_ovf;

  modport master (
    output in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_cout, out_ovf
  );
endinterface

// File: rtl/add_sub_seq.sv
// Sequencer around an external combinational add_sub unit.
// It collects operand A and then operand B with its add/sub select.
// It presents the registered operands to add_sub for one EXEC cycle,
// then captures and holds the result until downstream accepts it.
module add_sub_seq #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  add_sub_seq_if.slave    bus,
  output logic [SIZE-1:0] op_a,
  output logic [SIZE-1:0] op_b,
  output logic            op_sub,
  input  logic [SIZE-1:0] res_s,
  input  logic            res_cout,
  output logic [7:0]      txn_cnt
);

  typedef enum logic [1:0] {GET_A, GET_B, EXEC, HOLD} state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] op_a_q, op_b_q, out_s_q;
  logic            op_sub_q, out_cout_q, out_ovf_q, out_valid_q;
  logic [7:0]      txn_cnt_q;
  logic            out_fire;
  logic            a_msb, b_msb, s_msb, ovf;

  // Only the two collection states accept words; anything offered later is ignored.
  assign bus.in_ready = (state_q == GET_A) || (state_q == GET_B);
  assign out_fire     = out_valid_q && bus.out_ready;

  // Signed overflow from the sign bits of the live operands and the add_sub result.
  assign a_msb = op_a_q[SIZE-1];
  assign b_msb = op_b_q[SIZE-1];
  assign s_msb = res_s[SIZE-1];
  assign ovf   = op_sub_q ? ((a_msb != b_msb) && (s_msb != a_msb))
                          : ((a_msb == b_msb) && (s_msb != a_msb));

  // Next-state decode for the GET_A -> GET_B -> EXEC -> HOLD cycle.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      GET_A:   if (bus.in_valid) state_d = GET_B;
      GET_B:   if (bus.in_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (out_fire) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  // State register; reset abandons any partial or held transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Operand registers load only on an accepted word and are frozen in EXEC/HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, because they are visible outputs right after reset.
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sub_q <= 1'b0;
    end else if (bus.in_valid) begin
      if (state_q == GET_A) begin
        op_a_q <= bus.in_data;
      end else if (state_q == GET_B) begin
        op_b_q   <= bus.in_data;
        op_sub_q <= bus.in_sub;
      end
    end
  end

  // Capture the add_sub result in EXEC and hold it with out_valid until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (state_q == EXEC) begin
      out_s_q     <= res_s;
      out_cout_q  <= res_cout;
      out_ovf_q   <= ovf;
      out_valid_q <= 1'b1;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  // Completed output handshakes; the counter wraps freely at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_q <= 8'd0;
    end else if (out_fire) begin
      txn_cnt_q <= txn_cnt_q + 8'd1;
    end
  end

  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign op_sub        = op_sub_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = out_valid_q;
  assign txn_cnt       = txn_cnt_q;

endmodule
